// File: rtl/ms_rr_relay.sv
// ms_rr_relay: N-input round-robin master/slave relay.
// Collects one item from any offering slave channel (SECTION_A), then
// presents it on the single master output until consumed (SECTION_B).
// In accumulate mode (shared_in=1) the accepted data is added to the
// previously held value, wrapping modulo 2^W.
module ms_rr_relay #(
  parameter int N = 4,
  parameter int W = 32,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N*W-1:0] s_in_data,
  input  logic [N-1:0]  s_in_sync,
  output logic [N-1:0]  s_in_notify,
  output logic [W-1:0]  s_out_data,
  output logic [CW-1:0] s_out_chan,
  output logic          s_out_notify,
  input  logic          s_out_sync,
  input  logic          shared_in,
  output logic          section
);

  localparam logic SECTION_A = 1'b0;
  localparam logic SECTION_B = 1'b1;

  logic          section_signal;
  logic          section_next;
  logic [W-1:0]  val_signal;
  logic [CW-1:0] chan_signal;
  logic [CW-1:0] rr_ptr;
  logic          grant_vld;
  logic [CW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic          accept;

  // Modulo-2^W accumulation; the carry out is intentionally dropped.
  function automatic logic [W-1:0] acc_wrap(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    logic [W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[W-1:0];
  endfunction

  // Round-robin search: first offering channel at or above rr_ptr, else
  // first offering channel below rr_ptr (the wrapped part of the ring).
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    for (int k = 0; k < N; k++) begin
      if (!grant_vld && s_in_sync[k] && (CW'(k) >= rr_ptr)) begin
        grant_vld = 1'b1;
        grant     = CW'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!grant_vld && s_in_sync[k] && (CW'(k) < rr_ptr)) begin
        grant_vld = 1'b1;
        grant     = CW'(k);
      end
    end
  end

  // Select the granted channel's data word.
  always_comb begin
    grant_data = '0;
    for (int k = 0; k < N; k++) begin
      if (grant == CW'(k)) grant_data = s_in_data[k*W +: W];
    end
  end

  // A transfer happens only while collecting and never under reset.
  assign accept = (section_signal == SECTION_A) && grant_vld && !rst;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) section_signal <= SECTION_A;
    else     section_signal <= section_next;
  end

  // Next-state logic: collect until a grant, present until consumed.
  always_comb begin
    section_next = section_signal;
    case (section_signal)
      SECTION_A: if (grant_vld) section_next = SECTION_B;
      SECTION_B: if (s_out_sync) section_next = SECTION_A;
      default:   section_next = SECTION_A;
    endcase
  end

  // Output decode: accept strobe while collecting, valid while presenting.
  always_comb begin
    s_in_notify  = '0;
    s_out_notify = 1'b0;
    if (section_signal == SECTION_B) begin
      s_out_notify = 1'b1;
    end else if (grant_vld && !rst) begin
      for (int k = 0; k < N; k++) s_in_notify[k] = (grant == CW'(k));
    end
  end

  // Captured value, source tag and round-robin pointer update on accept;
  // val_signal is kept after consumption as the accumulate base.
  always_ff @(posedge clk) begin
    if (rst) begin
      val_signal  <= '0;
      chan_signal <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      val_signal  <= shared_in ? acc_wrap(val_signal, grant_data) : grant_data;
      chan_signal <= grant;
      rr_ptr      <= (grant == CW'(N-1)) ? '0 : grant + 1'b1;
    end
  end

  assign s_out_data = val_signal;
  assign s_out_chan = chan_signal;
  assign section    = section_signal;

endmodule

// File: tb/tb_ms_rr_relay.sv
// Directed bench for ms_rr_relay: one 32-bit instance for transfer,
// round-robin, backpressure and reset cases, one 8-bit instance for
// accumulate wrap-around.
module tb_ms_rr_relay;

  localparam int N  = 4;
  localparam int WA = 32;
  localparam int WB = 8;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*WA-1:0] a_data;
  logic [N-1:0]    a_sync, a_notify;
  logic [WA-1:0]   a_out;
  logic [CW-1:0]   a_chan;
  logic            a_onot, a_osync, a_shared, a_sec;

  logic [N*WB-1:0] b_data;
  logic [N-1:0]    b_sync, b_notify;
  logic [WB-1:0]   b_out;
  logic [CW-1:0]   b_chan;
  logic            b_onot, b_osync, b_shared, b_sec;

  ms_rr_relay #(.N(N), .W(WA)) dut_a (
    .clk(clk), .rst(rst),
    .s_in_data(a_data), .s_in_sync(a_sync), .s_in_notify(a_notify),
    .s_out_data(a_out), .s_out_chan(a_chan), .s_out_notify(a_onot),
    .s_out_sync(a_osync), .shared_in(a_shared), .section(a_sec)
  );

  ms_rr_relay #(.N(N), .W(WB)) dut_b (
    .clk(clk), .rst(rst),
    .s_in_data(b_data), .s_in_sync(b_sync), .s_in_notify(b_notify),
    .s_out_data(b_out), .s_out_chan(b_chan), .s_out_notify(b_onot),
    .s_out_sync(b_osync), .shared_in(b_shared), .section(b_sec)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_data = '0; a_sync = '0; a_osync = 1'b0; a_shared = 1'b0;
    b_data = '0; b_sync = '0; b_osync = 1'b0; b_shared = 1'b0;
    step(); step();
    #1;
    check("rst_onot",   64'(a_onot),   64'd0);
    check("rst_notify", 64'(a_notify), 64'd0);
    check("rst_data",   64'(a_out),    64'd0);
    check("rst_chan",   64'(a_chan),   64'd0);
    check("rst_sec",    64'(a_sec),    64'd0);
    rst = 1'b0;

    // idle for five cycles
    repeat (5) step();
    #1;
    check("idle_onot",   64'(a_onot),   64'd0);
    check("idle_notify", 64'(a_notify), 64'd0);
    check("idle_data",   64'(a_out),    64'd0);
    check("idle_sec",    64'(a_sec),    64'd0);

    // single transfer on channel 2
    a_data[2*WA +: WA] = 32'h0000_1234;
    a_sync = 4'b0100;
    #1;
    check("single_innot", 64'(a_notify), 64'(4'b0100));
    check("single_onot0", 64'(a_onot),   64'd0);
    step();
    a_sync = '0;
    #1;
    check("single_onot", 64'(a_onot),   64'd1);
    check("single_data", 64'(a_out),    64'h1234);
    check("single_chan", 64'(a_chan),   64'd2);
    check("single_sec",  64'(a_sec),    64'd1);
    check("single_blk",  64'(a_notify), 64'd0);
    a_osync = 1'b1;
    step();
    a_osync = 1'b0;
    #1;
    check("single_back", 64'(a_sec),  64'd0);
    check("single_off",  64'(a_onot), 64'd0);
    repeat (3) step();
    check("nosync_hold", 64'(a_sec), 64'd0);

    // round robin from reset with every channel offering
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) a_data[k*WA +: WA] = 32'hA000_0000 + 32'(k);
    a_sync  = 4'hF;
    a_osync = 1'b1;
    for (int g = 0; g < 6; g++) begin
      int exp_ch;
      exp_ch = g % N;
      #1;
      check("rr_grant", 64'(a_notify), 64'(4'b0001 << exp_ch));
      check("rr_secA",  64'(a_sec),    64'd0);
      step();
      #1;
      check("rr_chan",  64'(a_chan),   64'(exp_ch));
      check("rr_data",  64'(a_out),    64'h0A000_0000 + 64'(exp_ch));
      check("rr_onot",  64'(a_onot),   64'd1);
      check("rr_blk",   64'(a_notify), 64'd0);
      step();
    end

    // backpressure: pointer now at 2
    a_osync = 1'b0;
    #1;
    check("bp_grant", 64'(a_notify), 64'(4'b0100));
    step();
    a_data[2*WA +: WA] = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_data",  64'(a_out),    64'hA000_0002);
      check("bp_chan",  64'(a_chan),   64'd2);
      check("bp_blk",   64'(a_notify), 64'd0);
      check("bp_onot",  64'(a_onot),   64'd1);
      step();
    end
    a_osync = 1'b1;
    step();
    a_osync = 1'b0;
    #1;
    check("bp_next", 64'(a_notify), 64'(4'b1000));

    // reset while presenting channel 3
    step();
    #1;
    check("mid_onot", 64'(a_onot), 64'd1);
    check("mid_chan", 64'(a_chan), 64'd3);
    rst = 1'b1;
    step();
    #1;
    check("mid_rst_onot",   64'(a_onot),   64'd0);
    check("mid_rst_data",   64'(a_out),    64'd0);
    check("mid_rst_chan",   64'(a_chan),   64'd0);
    check("mid_rst_sec",    64'(a_sec),    64'd0);
    check("mid_rst_notify", 64'(a_notify), 64'd0);
    rst = 1'b0;
    #1;
    check("mid_grant0", 64'(a_notify), 64'(4'b0001));
    step();
    #1;
    check("mid_chan0", 64'(a_chan), 64'd0);
    check("mid_data0", 64'(a_out),  64'hA000_0000);
    a_sync  = '0;
    a_osync = 1'b1;
    step();
    a_osync = 1'b0;

    // accumulate wrap on the 8-bit instance
    b_shared = 1'b1;
    b_data[1*WB +: WB] = 8'hF0;
    b_sync = 4'b0010;
    #1;
    check("acc_grant1", 64'(b_notify), 64'(4'b0010));
    step();
    b_sync = '0;
    #1;
    check("acc_first", 64'(b_out),  64'hF0);
    check("acc_chan1", 64'(b_chan), 64'd1);
    b_osync = 1'b1;
    step();
    b_osync = 1'b0;
    b_data[3*WB +: WB] = 8'h20;
    b_sync = 4'b1000;
    #1;
    check("acc_grant3", 64'(b_notify), 64'(4'b1000));
    step();
    b_sync = '0;
    #1;
    check("acc_wrap",  64'(b_out),  64'h10);
    check("acc_chan3", 64'(b_chan), 64'd3);
    check("acc_onot",  64'(b_onot), 64'd1);
    b_osync = 1'b1;
    step();
    b_osync  = 1'b0;
    b_shared = 1'b0;
    b_data[0 +: WB] = 8'h05;
    b_sync = 4'b0001;
    step();
    b_sync = '0;
    #1;
    check("pass_data", 64'(b_out),  64'h05);
    check("pass_chan", 64'(b_chan), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
